// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one QSPI flash read port between a video stream and an audio stream.
// Latency: qspi_start pulses the cycle after the IDLE cycle that picks a grant; one read in flight at a time.
// Backpressure: no grant while qspi_busy=1; a second aud_req while one is pending is flagged on aud_overrun.
//
// Ports:
//   clk, rst           pixel clock, synchronous active-high reset
//   vid_level          video buffer occupancy in words (0..4)
//   rewind             pulse: restart the video stream at VID_BASE
//   aud_req            pulse: one audio sample needed
//   qspi_busy/done     QSPI controller status / read-complete pulse
//   qspi_start/addr/len/aud_sel   read launch and its registered descriptor
//   aud_overrun        pulse: audio request dropped because one was already pending
//
// Optional feature: define FLASH_ARB_STARVE_EN to add an audio anti-starvation counter.

module flash_arbiter #(
   parameter logic [23:0] VID_BASE  = 24'h000000,
   parameter logic [23:0] VID_END   = 24'h7FFFFF,
   parameter logic [23:0] AUD_BASE  = 24'h800000,
   parameter logic [23:0] AUD_END   = 24'hFFFFFF,
   parameter int          VID_BURST = 4,
   parameter int          LOW_WATER = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  vid_level,
   input  logic        rewind,
   input  logic        aud_req,
   input  logic        qspi_busy,
   input  logic        qspi_done,
   output logic        qspi_start,
   output logic [23:0] qspi_addr,
   output logic [2:0]  qspi_len,
   output logic        aud_sel,
   output logic        aud_overrun
);

   localparam logic [3:0]  BURST_W   = 4'(VID_BURST);
   localparam logic [2:0]  BURST_LEN = 3'(VID_BURST);
   localparam logic [3:0]  LOW_W     = 4'(LOW_WATER);
   localparam logic [24:0] VID_STEP  = 25'(3 * VID_BURST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [23:0] vid_ptr_q, vid_ptr_d;
   logic [23:0] aud_ptr_q, aud_ptr_d;
   logic        aud_pend_q, aud_pend_d;
   logic        rewind_pend_q, rewind_pend_d;
   logic        start_q, start_d;
   logic [23:0] addr_q, addr_d;
   logic [2:0]  len_q, len_d;
   logic        sel_q, sel_d;
   logic        overrun_q, overrun_d;

   logic        vid_act;
   logic        starve_force;
   logic        grant_vid;
   logic        grant_aud;
   logic [24:0] vid_next;
   logic [24:0] aud_next;
   logic [23:0] vid_issue_addr;

`ifdef FLASH_ARB_STARVE_EN
   logic [7:0]  starve_cnt_q, starve_cnt_d;
`endif

   // Grant decision, only meaningful in IDLE with the controller free.
   always_comb begin
      vid_act   = (({1'b0, vid_level} + BURST_W) <= 4'd4);
`ifdef FLASH_ARB_STARVE_EN
      starve_force = (starve_cnt_q == 8'd255) && aud_pend_q;
`else
      starve_force = 1'b0;
`endif
      grant_vid = 1'b0;
      grant_aud = 1'b0;
      if ((state_q == IDLE) && !qspi_busy) begin
         if (starve_force) begin
            grant_aud = 1'b1;
         end else if ({1'b0, vid_level} < LOW_W) begin
            // Starving buffer wins even if a full burst would not fit yet.
            grant_vid = 1'b1;
         end else if (aud_pend_q) begin
            grant_aud = 1'b1;
         end else if (vid_act) begin
            grant_vid = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      vid_ptr_d     = vid_ptr_q;
      aud_ptr_d     = aud_ptr_q;
      rewind_pend_d = rewind_pend_q;
      start_d       = 1'b0;
      addr_d        = addr_q;
      len_d         = len_q;
      sel_d         = sel_q;

      vid_next = {1'b0, vid_ptr_q} + VID_STEP;
      aud_next = {1'b0, aud_ptr_q} + 25'd1;
      // A rewind arriving in the same IDLE cycle as a video grant must
      // read from the restart point, otherwise the stream skips a burst.
      vid_issue_addr = rewind ? VID_BASE : vid_ptr_q;

      case (state_q)
         IDLE: begin
            if (rewind) begin
               vid_ptr_d = VID_BASE;
            end
            if (grant_vid || grant_aud) begin
               state_d = ISSUE;
               start_d = 1'b1;
               addr_d  = grant_aud ? aud_ptr_q : vid_issue_addr;
               len_d   = grant_aud ? 3'd1 : BURST_LEN;
               sel_d   = grant_aud;
            end
         end
         ISSUE: begin
            state_d = WAIT;
            if (rewind) begin
               rewind_pend_d = 1'b1;
            end
         end
         WAIT: begin
            if (rewind) begin
               rewind_pend_d = 1'b1;
            end
            if (qspi_done) begin
               state_d       = IDLE;
               rewind_pend_d = 1'b0;
               // A deferred rewind replaces the video advance outright.
               if (rewind_pend_q || rewind) begin
                  vid_ptr_d = VID_BASE;
               end else if (!sel_q) begin
                  vid_ptr_d = (vid_next > {1'b0, VID_END}) ? VID_BASE : vid_next[23:0];
               end
               if (sel_q) begin
                  aud_ptr_d = (aud_next > {1'b0, AUD_END}) ? AUD_BASE : aud_next[23:0];
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A request arriving with the audio issue refills the single slot.
      aud_pend_d = aud_req | (aud_pend_q & ~grant_aud);
      overrun_d  = aud_req & aud_pend_q & ~grant_aud;
   end

`ifdef FLASH_ARB_STARVE_EN
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant_aud) begin
         starve_cnt_d = 8'd0;
      end else if (grant_vid && aud_pend_q && (starve_cnt_q != 8'd255)) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= 8'd0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         vid_ptr_q     <= VID_BASE;
         aud_ptr_q     <= AUD_BASE;
         aud_pend_q    <= 1'b0;
         rewind_pend_q <= 1'b0;
         start_q       <= 1'b0;
         addr_q        <= 24'd0;
         len_q         <= 3'd0;
         sel_q         <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         vid_ptr_q     <= vid_ptr_d;
         aud_ptr_q     <= aud_ptr_d;
         aud_pend_q    <= aud_pend_d;
         rewind_pend_q <= rewind_pend_d;
         start_q       <= start_d;
         addr_q        <= addr_d;
         len_q         <= len_d;
         sel_q         <= sel_d;
         overrun_q     <= overrun_d;
      end
   end

   assign qspi_start  = start_q;
   assign qspi_addr   = addr_q;
   assign qspi_len    = len_q;
   assign aud_sel     = sel_q;
   assign aud_overrun = overrun_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter: instance a uses default parameters,
// instance b uses VID_END=0x00000B to exercise video pointer wrap.
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_flash_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  a_lvl, b_lvl;
   logic        a_rew, b_rew, a_areq, b_areq, a_busy, b_busy, a_done, b_done;
   logic        a_start, b_start, a_sel, b_sel, a_ovr, b_ovr;
   logic [23:0] a_addr, b_addr;
   logic [2:0]  a_len, b_len;

   int checks   = 0;
   int failures = 0;
   int seen;

   flash_arbiter u_a (
      .clk(clk), .rst(rst), .vid_level(a_lvl), .rewind(a_rew), .aud_req(a_areq),
      .qspi_busy(a_busy), .qspi_done(a_done), .qspi_start(a_start), .qspi_addr(a_addr),
      .qspi_len(a_len), .aud_sel(a_sel), .aud_overrun(a_ovr)
   );

   flash_arbiter #(.VID_END(24'h00000B)) u_b (
      .clk(clk), .rst(rst), .vid_level(b_lvl), .rewind(b_rew), .aud_req(b_areq),
      .qspi_busy(b_busy), .qspi_done(b_done), .qspi_start(b_start), .qspi_addr(b_addr),
      .qspi_len(b_len), .aud_sel(b_sel), .aud_overrun(b_ovr)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for a launch, checks its descriptor, then plays the
   // flash controller: busy for two cycles, optional rewind while in WAIT,
   // then done with vid_level switched to lvl_after.
   task automatic do_read(input bit inst, input string tag, input logic [23:0] ea,
                          input logic [2:0] el, input logic es,
                          input logic [2:0] lvl_after, input bit rew);
      for (int i = 0; i < 8; i++) begin
         if ((inst ? b_start : a_start) === 1'b1) break;
         tick();
      end
      check({tag, "_start"}, inst ? b_start : a_start, 32'd1);
      check({tag, "_addr"},  inst ? b_addr  : a_addr,  {8'd0, ea});
      check({tag, "_len"},   inst ? b_len   : a_len,   {29'd0, el});
      check({tag, "_sel"},   inst ? b_sel   : a_sel,   {31'd0, es});
      if (inst) b_busy = 1'b1; else a_busy = 1'b1;
      tick();
      check({tag, "_pulse"}, inst ? b_start : a_start, 32'd0);
      if (rew) begin
         if (inst) b_rew = 1'b1; else a_rew = 1'b1;
      end
      tick();
      a_rew = 1'b0;
      b_rew = 1'b0;
      check({tag, "_hold"}, inst ? b_addr : a_addr, {8'd0, ea});
      if (inst) begin
         b_busy = 1'b0; b_done = 1'b1; b_lvl = lvl_after;
      end else begin
         a_busy = 1'b0; a_done = 1'b1; a_lvl = lvl_after;
      end
      tick();
      a_done = 1'b0;
      b_done = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_lvl = 3'd0; b_lvl = 3'd3;
      a_rew = 1'b0; b_rew = 1'b0; a_areq = 1'b0; b_areq = 1'b0;
      a_busy = 1'b0; b_busy = 1'b0; a_done = 1'b0; b_done = 1'b0;
      tick(); tick(); tick();

      // Reset values.
      check("rst_start",   a_start, 32'd0);
      check("rst_addr",    a_addr,  32'd0);
      check("rst_len",     a_len,   32'd0);
      check("rst_sel",     a_sel,   32'd0);
      check("rst_overrun", a_ovr,   32'd0);

      // First IDLE edge after reset decides video; start is visible right after it.
      rst = 1'b0;
      tick();
      check("rst_to_start", a_start, 32'd1);
      do_read(1'b0, "vid_first", 24'h000000, 3'd4, 1'b0, 3'd3, 1'b0);

      // Audio with a comfortable video buffer; audio pointer advances by one.
      a_areq = 1'b1; tick(); a_areq = 1'b0;
      do_read(1'b0, "aud0", 24'h800000, 3'd1, 1'b1, 3'd3, 1'b0);
      a_areq = 1'b1; tick(); a_areq = 1'b0;
      do_read(1'b0, "aud1", 24'h800001, 3'd1, 1'b1, 3'd3, 1'b0);

      // Low buffer beats pending audio; audio follows once the level reaches 2.
      a_lvl = 3'd1; a_areq = 1'b1; tick(); a_areq = 1'b0;
      check("lowwater_ovr", a_ovr, 32'd0);
      do_read(1'b0, "low_vid", 24'h00000C, 3'd4, 1'b0, 3'd2, 1'b0);
      do_read(1'b0, "low_aud", 24'h800002, 3'd1, 1'b1, 3'd3, 1'b0);

      // Walk video to 0x30, rewind in WAIT, next video read restarts at 0.
      a_lvl = 3'd0;
      do_read(1'b0, "vid18", 24'h000018, 3'd4, 1'b0, 3'd0, 1'b0);
      do_read(1'b0, "vid24", 24'h000024, 3'd4, 1'b0, 3'd0, 1'b0);
      do_read(1'b0, "vid30", 24'h000030, 3'd4, 1'b0, 3'd0, 1'b1);
      do_read(1'b0, "rewound", 24'h000000, 3'd4, 1'b0, 3'd3, 1'b0);

      // Two audio requests while the controller is busy: one overrun pulse, no launch.
      a_busy = 1'b1; a_areq = 1'b1;
      tick();
      check("ovr_first_req", a_ovr, 32'd0);
      check("busy_no_start0", a_start, 32'd0);
      tick();
      a_areq = 1'b0;
      check("ovr_pulse", a_ovr, 32'd1);
      check("busy_no_start1", a_start, 32'd0);
      tick();
      check("ovr_one_cycle", a_ovr, 32'd0);
      a_busy = 1'b0;
      do_read(1'b0, "aud_after_ovr", 24'h800003, 3'd1, 1'b1, 3'd3, 1'b0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen += int'(a_start);
      end
      check("no_extra_aud", seen, 32'd0);

      // aud_req on the issue cycle of an audio read is kept, with no overrun.
      a_busy = 1'b1; a_areq = 1'b1; tick(); a_areq = 1'b0;
      a_busy = 1'b0; a_areq = 1'b1; tick(); a_areq = 1'b0;
      check("issue_req_ovr", a_ovr, 32'd0);
      do_read(1'b0, "aud_issue", 24'h800004, 3'd1, 1'b1, 3'd3, 1'b0);
      do_read(1'b0, "aud_kept",  24'h800005, 3'd1, 1'b1, 3'd3, 1'b0);

      // Stray done in IDLE must not move the video pointer.
      a_done = 1'b1; tick(); a_done = 1'b0; tick();
      check("stray_done_start", a_start, 32'd0);
      a_lvl = 3'd0;
      do_read(1'b0, "after_stray", 24'h00000C, 3'd4, 1'b0, 3'd3, 1'b0);

      // Reset mid-transaction abandons the read; late done is ignored.
      a_lvl = 3'd0; tick();
      check("mid_start", a_start, 32'd1);
      check("mid_addr",  a_addr,  32'h000018);
      a_busy = 1'b1; tick();
      rst = 1'b1; tick();
      check("mid_rst_start", a_start, 32'd0);
      check("mid_rst_addr",  a_addr,  32'd0);
      check("mid_rst_len",   a_len,   32'd0);
      rst = 1'b0; a_lvl = 3'd3; a_busy = 1'b0; a_done = 1'b1;
      tick();
      a_done = 1'b0;
      tick();
      check("late_done_start", a_start, 32'd0);
      a_lvl = 3'd0;
      do_read(1'b0, "post_rst", 24'h000000, 3'd4, 1'b0, 3'd3, 1'b0);

      // Instance b: 0x0 + 12 exceeds VID_END=0xB, so every read wraps to 0.
      b_lvl = 3'd0;
      do_read(1'b1, "wrap0", 24'h000000, 3'd4, 1'b0, 3'd0, 1'b0);
      do_read(1'b1, "wrap1", 24'h000000, 3'd4, 1'b0, 3'd0, 1'b0);
      do_read(1'b1, "wrap2", 24'h000000, 3'd4, 1'b0, 3'd0, 1'b0);
      do_read(1'b1, "wrap3", 24'h000000, 3'd4, 1'b0, 3'd3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
